mrr_decode_output_arbiter: RTL and testbench
============================================

Name: mrr_decode_output_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single decoded-output AXI-stream (32-bit words) between the NUM_DECODE_PATHWAYS loopback/decoder pathways.
- Each pathway presents a complete packet framed by tlast. A grant is held from the first beat to the tlast beat, so packets never interleave.
- The output is registered. The block sits between the per-pathway decoder outputs and the top-level o_decoded_* port.

Parameters:
- NUM_PATHWAYS, 4, number of requesting decode pathways (1..16).
- IDX_WIDTH, 2, width of the pathway index; 2**IDX_WIDTH >= NUM_PATHWAYS.
- DATA_WIDTH, 32, stream word width.
- TIMEOUT_WIDTH, 16, width of the stall watchdog counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_tdata  in  NUM_PATHWAYS*DATA_WIDTH  pathway p occupies bits [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH].
- i_tvalid  in  NUM_PATHWAYS  per-pathway valid.
- i_tlast  in  NUM_PATHWAYS  per-pathway end of packet.
- i_tready  out  NUM_PATHWAYS  per-pathway ready.
- o_tdata  out  DATA_WIDTH  arbitrated data.
- o_tvalid  out  1  output valid.
- o_tlast  out  1  output end of packet.
- o_tready  in  1  downstream ready.
- o_src_idx  out  IDX_WIDTH  pathway that owns the current o_tdata beat.
- timeout_cycles  in  TIMEOUT_WIDTH  watchdog limit; 0 disables the watchdog.
- clear_flags  in  1  one-cycle pulse that clears timeout_flags.
- timeout_flags  out  NUM_PATHWAYS  sticky per-pathway timeout flags.
- busy  out  1  high while a grant is held or an output beat is pending.

Behaviour:
- Reset values: o_tvalid=0, o_tlast=0, o_tdata=0, o_src_idx=0, i_tready=0, timeout_flags=0, busy=0. State=IDLE, last_grant=NUM_PATHWAYS-1, so pathway 0 has first priority.
- Reset mid-packet: the in-flight packet is abandoned, and the output register is cleared in the same cycle.
- State IDLE:
  - If any i_tvalid is set, select the first asserted pathway searching last_grant+1, last_grant+2, ... modulo NUM_PATHWAYS.
  - Register the result in grant and go to GRANT next cycle.
  - i_tready stays 0 throughout IDLE.
- State GRANT:
  - i_tready[grant] = (!o_tvalid | o_tready); all other i_tready bits are 0.
  - A beat is accepted when i_tvalid[grant] & i_tready[grant]. On acceptance, the output register loads tdata/tlast, o_src_idx=grant, o_tvalid=1.
  - The output register clears o_tvalid when o_tready=1 and no new beat is loaded.
  - An accepted beat with tlast=1: last_grant <= grant, go to IDLE.
- Latency:
  - A request arriving in IDLE at cycle n gives a grant at n+1.
  - The first beat is accepted at n+1 and appears on o_tvalid at n+2.
  - Throughput is one beat per cycle within a packet. There is one arbitration (IDLE) cycle between consecutive packets.
- Simultaneous requests: round-robin only; no pathway is granted twice in a row while another pathway is requesting.
- A granted pathway dropping i_tvalid mid-packet: the grant is held, with no timeout (feature disabled) or until timeout (feature enabled).
- Output stability: o_tdata, o_tlast and o_src_idx are held constant while o_tvalid=1 and o_tready=0.
- busy = (state==GRANT) | o_tvalid.
- timeout_flags are written only by the optional feature. clear_flags has priority over a same-cycle set.

Optional Feature:
- Macro: MRR_ARB_TIMEOUT_EN.
- With the macro defined, in GRANT:
  - A TIMEOUT_WIDTH counter increments on each cycle with i_tvalid[grant]=0. It resets on any accepted beat and on entering GRANT.
  - When the counter reaches timeout_cycles (nonzero), the arbiter loads a terminator beat into the output register: o_tdata = {16'hDEAD, zero-extended grant index}, o_tlast=1, o_src_idx=grant.
  - The terminator loads only when the output register is free (!o_tvalid | o_tready).
  - timeout_flags[grant] is set, last_grant <= grant, and the state goes to IDLE.
- Without the macro: no counter; timeout_cycles is ignored; timeout_flags stay 0.

Test Plan:
- Single packet: p2 sends 3 beats 0x11,0x22,0x33 (tlast on 3rd) with o_tready=1 → o_tvalid rises 2 cycles after request, o_src_idx=2, 3 consecutive beats, o_tlast on 0x33, busy falls after.
- Contention: p0..p3 all request 2-beat packets simultaneously → output order p0,p1,p2,p3. Each packet is contiguous, with one gap cycle between packets.
- Back-pressure: p1 sends 4 beats while o_tready toggles 1,0,0,1,... → no beat lost or duplicated. o_tdata is held while o_tready=0, and i_tready[1]=0 during the stall.
- Fairness: p0 requests continuously, p3 requests once → after p0's current packet, p3 is granted before p0's next packet.
- Reset: assert rst mid-packet of p1 → next cycle all outputs are at their reset values. After release, a p1 request is granted afresh with the packet restarted from beat 0.
- Timeout (MRR_ARB_TIMEOUT_EN, timeout_cycles=8): p2 sends 1 beat, then i_tvalid[2]=0 → after 8 stalled cycles, output 0xDEAD0002 with tlast=1, timeout_flags=4'b0100. clear_flags pulse → flags return to 0.

Source files
------------

// File: rtl/mrr_decode_output_arbiter_if.sv
// mrr_decode_output_arbiter_if
// Stream bundle between the decode pathways, the arbiter and the decoded-output sink.
//   i_tdata   : NUM_PATHWAYS packed words; pathway p sits at [DATA_WIDTH*(p+1)-1 -: DATA_WIDTH]
//   i_tvalid  : per-pathway valid
//   i_tlast   : per-pathway end of packet
//   i_tready  : per-pathway ready, driven by the arbiter
//   o_tdata   : arbitrated word
//   o_tvalid  : output valid
//   o_tlast   : output end of packet
//   o_tready  : downstream ready
//   o_src_idx : pathway that owns the current output beat
// Modports: slave = arbiter view, master = pathway/sink view.
interface mrr_decode_output_arbiter_if #(
    parameter int NUM_PATHWAYS = 4,
    parameter int IDX_WIDTH    = 2,
    parameter int DATA_WIDTH   = 32
);
    logic [NUM_PATHWAYS*DATA_WIDTH-1:0] i_tdata;
    logic [NUM_PATHWAYS-1:0]            i_tvalid;
    logic [NUM_PATHWAYS-1:0]            i_tlast;
    logic [NUM_PATHWAYS-1:0]            i_tready;
    logic [DATA_WIDTH-1:0]              o_tdata;
    logic                               o_tvalid;
    logic                               o_tlast;
    logic                               o_tready;
    logic [IDX_WIDTH-1:0]               o_src_idx;

    modport slave (
        input  i_tdata, i_tvalid, i_tlast, o_tready,
        output i_tready, o_tdata, o_tvalid, o_tlast, o_src_idx
    );

    modport master (
        output i_tdata, i_tvalid, i_tlast, o_tready,
        input  i_tready, o_tdata, o_tvalid, o_tlast, o_src_idx
    );
endinterface

// File: rtl/mrr_decode_output_arbiter.sv
// mrr_decode_output_arbiter
// Packet-level round-robin arbiter sharing the decoded-output stream between the
// decode pathways. A grant is held from first beat to tlast; the output is registered.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus             : stream bundle (slave modport), see mrr_decode_output_arbiter_if
//   timeout_cycles  : stall watchdog limit, 0 disables
//   clear_flags     : pulse clearing timeout_flags (wins over a same-cycle set)
//   timeout_flags   : sticky per-pathway timeout flags
//   busy            : grant held or output beat pending
// Optional feature: define MRR_ARB_TIMEOUT_EN to enable the stall watchdog, which
// closes a stalled packet with a {16'hDEAD, grant} terminator beat.
//
// state | meaning
// IDLE  | arbitration cycle, no pathway ready
// GRANT | pathway 'grant' owns the output until its tlast beat (or a timeout)
module mrr_decode_output_arbiter #(
    parameter int NUM_PATHWAYS  = 4,
    parameter int IDX_WIDTH     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mrr_decode_output_arbiter_if.slave bus,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     clear_flags,
    output logic [NUM_PATHWAYS-1:0]  timeout_flags,
    output logic                     busy
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [IDX_WIDTH-1:0]    grant, grant_nxt;
    logic [IDX_WIDTH-1:0]    last_grant, last_grant_nxt;
    logic [IDX_WIDTH-1:0]    rr_sel, rr_cand;
    logic                    rr_any;

    logic                    gnt_valid, gnt_last;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    out_free, accept, term_fire;
    logic [DATA_WIDTH-1:0]   term_data;
    logic [NUM_PATHWAYS-1:0] ready;

    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid, out_last;
    logic [IDX_WIDTH-1:0]    out_src;

    // Round-robin search starting one past the last granted pathway.
    always_comb begin
        rr_sel  = last_grant;
        rr_any  = 1'b0;
        rr_cand = '0;
        for (int off = 1; off <= NUM_PATHWAYS; off++) begin
            rr_cand = IDX_WIDTH'((int'(last_grant) + off) % NUM_PATHWAYS);
            if (!rr_any && bus.i_tvalid[rr_cand]) begin
                rr_sel = rr_cand;
                rr_any = 1'b1;
            end
        end
    end

    // Mux of the granted pathway's stream.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int p = 0; p < NUM_PATHWAYS; p++) begin
            if (grant == IDX_WIDTH'(p)) begin
                gnt_valid = bus.i_tvalid[p];
                gnt_last  = bus.i_tlast[p];
                gnt_data  = bus.i_tdata[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_WIDTH'(NUM_PATHWAYS - 1);
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (rr_any) begin
                    grant_nxt = rr_sel;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if ((accept && gnt_last) || term_fire) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_free = !out_valid || bus.o_tready;
        ready    = '0;
        if (state == GRANT) ready[grant] = out_free;
        accept   = (state == GRANT) && gnt_valid && out_free;
        busy     = (state == GRANT) || out_valid;
    end

`ifdef MRR_ARB_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] stall_cnt;

    // Only reachable with gnt_valid low: out_free with a valid beat means accept.
    always_comb begin
        term_fire = (state == GRANT) && !accept && out_free &&
                    (timeout_cycles != '0) && (stall_cnt >= timeout_cycles);
        term_data = '0;
        term_data[DATA_WIDTH-1 -: 16] = 16'hDEAD;
        term_data[IDX_WIDTH-1:0]      = grant;
    end

    // Held at zero outside GRANT so every grant starts with a fresh count.
    always_ff @(posedge clk) begin
        if (rst || state != GRANT || accept) begin
            stall_cnt <= '0;
        end else if (!gnt_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_flags) begin
            timeout_flags <= '0;
        end else if (term_fire) begin
            timeout_flags[grant] <= 1'b1;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{timeout_cycles, clear_flags};

    always_comb begin
        term_fire     = 1'b0;
        term_data     = '0;
        timeout_flags = '0;
    end
`endif

    // Output register: data/last/src change only when a beat or terminator loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= gnt_last;
            out_data  <= gnt_data;
            out_src   <= grant;
        end else if (term_fire) begin
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            out_data  <= term_data;
            out_src   <= grant;
        end else if (bus.o_tready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.i_tready  = ready;
    assign bus.o_tdata   = out_data;
    assign bus.o_tvalid  = out_valid;
    assign bus.o_tlast   = out_last;
    assign bus.o_src_idx = out_src;
endmodule

// File: tb/tb_mrr_decode_output_arbiter.sv
// tb_mrr_decode_output_arbiter
// Directed bench for the decoded-output round-robin arbiter. Pathway sources are
// small per-pathway beat lists; output beats are logged with their cycle number.
module tb_mrr_decode_output_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] timeout_cycles;
    logic        clear_flags;
    logic [3:0]  timeout_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [32:0] src_mem [4][16];
    int          wr_ptr [4];
    int          rd_ptr [4];
    logic [34:0] obs[$];
    int          ostamp[$];

    mrr_decode_output_arbiter_if #(.NUM_PATHWAYS(4), .IDX_WIDTH(2), .DATA_WIDTH(32)) bus();

    mrr_decode_output_arbiter #(
        .NUM_PATHWAYS(4), .IDX_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT_WIDTH(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .timeout_cycles (timeout_cycles),
        .clear_flags    (clear_flags),
        .timeout_flags  (timeout_flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic src_clear();
        for (int p = 0; p < 4; p++) begin
            wr_ptr[p] = 0;
            rd_ptr[p] = 0;
        end
    endtask

    task automatic push(input int p, input logic last, input logic [31:0] d);
        src_mem[p][wr_ptr[p]] = {last, d};
        wr_ptr[p] = wr_ptr[p] + 1;
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            if (rd_ptr[p] < wr_ptr[p]) begin
                bus.i_tvalid[p]          = 1'b1;
                bus.i_tlast[p]           = src_mem[p][rd_ptr[p]][32];
                bus.i_tdata[p*32 +: 32]  = src_mem[p][rd_ptr[p]][31:0];
            end else begin
                bus.i_tvalid[p]          = 1'b0;
                bus.i_tlast[p]           = 1'b0;
                bus.i_tdata[p*32 +: 32]  = '0;
            end
        end
    endtask

    // Handshakes are sampled on the falling edge, sources advance after the rising edge.
    task automatic cycle();
        logic [3:0]  fire;
        logic        ofire;
        logic [34:0] obeat;
        @(negedge clk);
        fire  = bus.i_tvalid & bus.i_tready;
        ofire = bus.o_tvalid & bus.o_tready;
        obeat = {bus.o_src_idx, bus.o_tlast, bus.o_tdata};
        @(posedge clk);
        #1;
        cyc++;
        if (ofire) begin
            obs.push_back(obeat);
            ostamp.push_back(cyc);
        end
        for (int p = 0; p < 4; p++) if (fire[p]) rd_ptr[p] = rd_ptr[p] + 1;
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_clear();
        drive();
        cycle();
        cycle();
        rst = 1'b0;
        obs.delete();
        ostamp.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0]  pat;
        logic        stalled;
        logic [31:0] held;

        bus.o_tready   = 1'b1;
        bus.i_tvalid   = '0;
        bus.i_tlast    = '0;
        bus.i_tdata    = '0;
        timeout_cycles = '0;
        clear_flags    = 1'b0;
        do_reset();

        // Reset values
        check("rst_tvalid", bus.o_tvalid, 0);
        check("rst_tlast", bus.o_tlast, 0);
        check("rst_tdata", bus.o_tdata, 0);
        check("rst_src", bus.o_src_idx, 0);
        check("rst_tready", bus.i_tready, 0);
        check("rst_flags", timeout_flags, 0);
        check("rst_busy", busy, 0);

        // Single packet on pathway 2
        push(2, 1'b0, 32'h11);
        push(2, 1'b0, 32'h22);
        push(2, 1'b1, 32'h33);
        drive();
        #1;
        check("sp_idle_ready", bus.i_tready, 4'b0000);
        cycle();
        check("sp_grant_ready", bus.i_tready, 4'b0100);
        check("sp_n1_tvalid", bus.o_tvalid, 0);
        check("sp_n1_busy", busy, 1);
        cycle();
        check("sp_b0", {bus.o_tvalid, bus.o_src_idx, bus.o_tlast, bus.o_tdata}, {1'b1, 2'd2, 1'b0, 32'h11});
        cycle();
        check("sp_b1", {bus.o_tvalid, bus.o_src_idx, bus.o_tlast, bus.o_tdata}, {1'b1, 2'd2, 1'b0, 32'h22});
        cycle();
        check("sp_b2", {bus.o_tvalid, bus.o_src_idx, bus.o_tlast, bus.o_tdata}, {1'b1, 2'd2, 1'b1, 32'h33});
        check("sp_b2_busy", busy, 1);
        cycle();
        check("sp_done_tvalid", bus.o_tvalid, 0);
        check("sp_done_busy", busy, 0);
        check("sp_count", obs.size(), 3);

        // Contention: all four request 2-beat packets at once
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push(p, 1'b0, 32'(256*p));
            push(p, 1'b1, 32'(256*p + 1));
        end
        drive();
        for (int k = 0; k < 20; k++) cycle();
        check("ct_count", obs.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("ct_beat", obs[i], {2'(i/2), 1'(i%2), 32'(256*(i/2) + i%2)});
            if (i > 0) check("ct_gap", ostamp[i] - ostamp[i-1], (i%2 == 1) ? 1 : 2);
        end

        // Back-pressure on pathway 1
        obs.delete();
        ostamp.delete();
        src_clear();
        for (int b = 0; b < 4; b++) push(1, b == 3, 32'(32'h41 + b));
        drive();
        pat = 4'b1001;
        for (int k = 0; k < 24; k++) begin
            bus.o_tready = pat[k%4];
            #1;
            stalled = bus.o_tvalid && !bus.o_tready;
            held    = bus.o_tdata;
            if (stalled) check("bp_ready_low", bus.i_tready, 4'b0000);
            cycle();
            if (stalled) check("bp_hold", {bus.o_tvalid, bus.o_tdata}, {1'b1, held});
        end
        bus.o_tready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("bp_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) check("bp_beat", obs[i], {2'd1, i == 3, 32'(32'h41 + i)});

        // Fairness: p3 slips in between p0's packets
        obs.delete();
        ostamp.delete();
        src_clear();
        push(0, 1'b0, 32'h300);
        push(0, 1'b1, 32'h301);
        push(0, 1'b0, 32'h310);
        push(0, 1'b1, 32'h311);
        drive();
        cycle();
        push(3, 1'b0, 32'h330);
        push(3, 1'b1, 32'h331);
        drive();
        #1;
        for (int k = 0; k < 20; k++) cycle();
        check("fr_count", obs.size(), 6);
        check("fr_0", obs[0], {2'd0, 1'b0, 32'h300});
        check("fr_1", obs[1], {2'd0, 1'b1, 32'h301});
        check("fr_2", obs[2], {2'd3, 1'b0, 32'h330});
        check("fr_3", obs[3], {2'd3, 1'b1, 32'h331});
        check("fr_4", obs[4], {2'd0, 1'b0, 32'h310});
        check("fr_5", obs[5], {2'd0, 1'b1, 32'h311});

        // Reset in the middle of a p1 packet
        src_clear();
        for (int b = 0; b < 4; b++) push(1, b == 3, 32'(32'h51 + b));
        drive();
        cycle();
        cycle();
        check("mr_pre", {bus.o_tvalid, bus.o_tdata}, {1'b1, 32'h51});
        rst = 1'b1;
        src_clear();
        drive();
        cycle();
        check("mr_tvalid", bus.o_tvalid, 0);
        check("mr_tdata", bus.o_tdata, 0);
        check("mr_tlast", bus.o_tlast, 0);
        check("mr_src", bus.o_src_idx, 0);
        check("mr_ready", bus.i_tready, 0);
        check("mr_busy", busy, 0);
        rst = 1'b0;
        obs.delete();
        ostamp.delete();
        for (int b = 0; b < 4; b++) push(1, b == 3, 32'(32'h51 + b));
        drive();
        for (int k = 0; k < 12; k++) cycle();
        check("mr_count", obs.size(), 4);
        for (int i = 0; i < 4; i++) check("mr_beat", obs[i], {2'd1, i == 3, 32'(32'h51 + i)});

        // Stalled pathway 2 after one beat
        obs.delete();
        ostamp.delete();
        src_clear();
        timeout_cycles = 16'd8;
        push(2, 1'b0, 32'h61);
        drive();
        #1;
`ifdef MRR_ARB_TIMEOUT_EN
        for (int k = 0; k < 40 && obs.size() < 2; k++) cycle();
        check("to_count", obs.size(), 2);
        check("to_beat0", obs[0], {2'd2, 1'b0, 32'h61});
        check("to_term", obs[1], {2'd2, 1'b1, 32'hDEAD0002});
        check("to_delay", ostamp[1] - ostamp[0], 9);
        check("to_flags", timeout_flags, 4'b0100);
        check("to_busy", busy, 0);
        clear_flags = 1'b1;
        cycle();
        clear_flags = 1'b0;
        check("to_cleared", timeout_flags, 4'b0000);
`else
        for (int k = 0; k < 20; k++) cycle();
        check("st_count", obs.size(), 1);
        check("st_beat0", obs[0], {2'd2, 1'b0, 32'h61});
        check("st_busy", busy, 1);
        check("st_ready", bus.i_tready, 4'b0100);
        check("st_flags", timeout_flags, 4'b0000);
        push(2, 1'b1, 32'h62);
        drive();
        for (int k = 0; k < 5; k++) cycle();
        check("st_count2", obs.size(), 2);
        check("st_beat1", obs[1], {2'd2, 1'b1, 32'h62});
        check("st_done_busy", busy, 0);
        check("st_flags2", timeout_flags, 4'b0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
